// File: rtl/mac8_pp_sequencer_if.sv
// Operand, result and 4x4-multiplier handshake bundle for mac8_pp_sequencer.
// The master side drives operands and returns mul_p; the slave side is the sequencer.
interface mac8_pp_sequencer_if #(
    parameter int ACC_W = 20
) ();
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a;
    logic [7:0]       b;
    logic             clear_acc;
    logic [3:0]       mul_a;
    logic [3:0]       mul_b;
    logic [7:0]       mul_p;
    logic [15:0]      prod_out;
    logic [ACC_W-1:0] acc_out;
    logic             out_valid;
    logic             overflow;

    modport master (
        output in_valid, a, b, clear_acc, mul_p,
        input  in_ready, mul_a, mul_b, prod_out, acc_out, out_valid, overflow
    );

    modport slave (
        input  in_valid, a, b, clear_acc, mul_p,
        output in_ready, mul_a, mul_b, prod_out, acc_out, out_valid, overflow
    );
endinterface

// File: rtl/mac8_pp_sequencer.sv
// Iterative 8x8 unsigned MAC: feeds four nibble pairs to an external 4x4 multiplier,
// sums the shifted partial products into a 16-bit product and accumulates it.
module mac8_pp_sequencer #(
    parameter int ACC_W = 20
) (
    input logic                 clk,
    input logic                 rst,
    mac8_pp_sequencer_if.slave  bus
);

    localparam int SUM_W = ACC_W + 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PP0  = 3'd1;
    localparam logic [2:0] ST_PP1  = 3'd2;
    localparam logic [2:0] ST_PP2  = 3'd3;
    localparam logic [2:0] ST_PP3  = 3'd4;
    localparam logic [2:0] ST_ACC  = 3'd5;

    logic [2:0]       state;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic             clr_q;
    logic [15:0]      p_q;
    logic [15:0]      prod_q;
    logic [ACC_W-1:0] acc_q;
    logic             out_valid_q;
    logic             overflow_q;

    logic [3:0]       mul_a_c;
    logic [3:0]       mul_b_c;
    logic [15:0]      pp_term;
    logic [SUM_W-1:0] acc_sum;

    // NOTE: every variable assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        mul_a_c = 4'd0;
        mul_b_c = 4'd0;
        pp_term = 16'd0;
        case (state)
            ST_PP0: begin
                mul_a_c = a_q[3:0];
                mul_b_c = b_q[3:0];
                pp_term = {8'd0, bus.mul_p};
            end
            ST_PP1: begin
                mul_a_c = a_q[3:0];
                mul_b_c = b_q[7:4];
                pp_term = {4'd0, bus.mul_p, 4'd0};
            end
            ST_PP2: begin
                mul_a_c = a_q[7:4];
                mul_b_c = b_q[3:0];
                pp_term = {4'd0, bus.mul_p, 4'd0};
            end
            ST_PP3: begin
                mul_a_c = a_q[7:4];
                mul_b_c = b_q[7:4];
                pp_term = {bus.mul_p, 8'd0};
            end
            default: ;
        endcase
    end

    // The extra top bit of the sum is the carry-out that feeds the sticky overflow.
    assign acc_sum = SUM_W'(acc_q) + SUM_W'(p_q);

    // NOTE: all state here uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            clr_q       <= 1'b0;
            p_q         <= 16'd0;
            prod_q      <= 16'd0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        clr_q <= bus.clear_acc;
                        p_q   <= 16'd0;
                        state <= ST_PP0;
                    end
                end
                ST_PP0: begin
                    p_q   <= p_q + pp_term;
                    state <= ST_PP1;
                end
                ST_PP1: begin
                    p_q   <= p_q + pp_term;
                    state <= ST_PP2;
                end
                ST_PP2: begin
                    p_q   <= p_q + pp_term;
                    state <= ST_PP3;
                end
                ST_PP3: begin
                    p_q   <= p_q + pp_term;
                    state <= ST_ACC;
                end
                ST_ACC: begin
                    prod_q      <= p_q;
                    out_valid_q <= 1'b1;
                    state       <= ST_IDLE;
                    if (clr_q) begin
                        acc_q      <= ACC_W'(p_q);
                        overflow_q <= 1'b0;
                    end else begin
                        acc_q      <= acc_sum[ACC_W-1:0];
                        overflow_q <= overflow_q | acc_sum[ACC_W];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.mul_a     = mul_a_c;
    assign bus.mul_b     = mul_b_c;
    assign bus.prod_out  = prod_q;
    assign bus.acc_out   = acc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_mac8_pp_sequencer.sv
// Bench for mac8_pp_sequencer: ACC_W=20 and ACC_W=16 instances driven in lockstep and
// compared against an arithmetic MAC model with ideal 4x4 multipliers.
module tb_mac8_pp_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac8_pp_sequencer_if #(.ACC_W(20)) bus20 ();
    mac8_pp_sequencer_if #(.ACC_W(16)) bus16 ();

    mac8_pp_sequencer #(.ACC_W(20)) dut20 (.clk(clk), .rst(rst), .bus(bus20));
    mac8_pp_sequencer #(.ACC_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    // Ideal combinational 4x4 multipliers.
    assign bus20.mul_p = {4'd0, bus20.mul_a} * {4'd0, bus20.mul_b};
    assign bus16.mul_p = {4'd0, bus16.mul_a} * {4'd0, bus16.mul_b};

    int n_checks = 0;
    int n_fails  = 0;

    longint unsigned acc20_m, acc16_m;
    bit              ovf20_m, ovf16_m;
    logic [15:0]     prod_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        bus20.in_valid = v; bus20.a = a; bus20.b = b; bus20.clear_acc = c;
        bus16.in_valid = v; bus16.a = a; bus16.b = b; bus16.clear_acc = c;
    endtask

    task automatic model_reset();
        acc20_m = 0; acc16_m = 0; ovf20_m = 0; ovf16_m = 0; prod_m = 16'd0;
    endtask

    task automatic model_op(input logic [7:0] a, input logic [7:0] b, input logic clr);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        prod_m = p[15:0];
        if (clr) begin
            acc20_m = p; acc16_m = p; ovf20_m = 0; ovf16_m = 0;
        end else begin
            if (acc20_m + p >= (64'd1 << 20)) ovf20_m = 1;
            if (acc16_m + p >= (64'd1 << 16)) ovf16_m = 1;
            acc20_m = (acc20_m + p) % (64'd1 << 20);
            acc16_m = (acc16_m + p) % (64'd1 << 16);
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, "_prod20"}, bus20.prod_out, prod_m);
        check({tag, "_acc20"},  bus20.acc_out,  acc20_m[31:0]);
        check({tag, "_ovf20"},  bus20.overflow, ovf20_m);
        check({tag, "_prod16"}, bus16.prod_out, prod_m);
        check({tag, "_acc16"},  bus16.acc_out,  acc16_m[31:0]);
        check({tag, "_ovf16"},  bus16.overflow, ovf16_m);
    endtask

    // Starts at #1 after an edge; returns at #1 after the edge that shows out_valid.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic clr, input bit hold);
        int         waited = 0;
        logic [3:0] ea, eb;
        while (bus20.in_ready !== 1'b1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ready_before_op", bus20.in_ready, 1'b1);
        drive(1'b1, a, b, clr);
        @(posedge clk); #1;
        model_op(a, b, clr);
        for (int c = 1; c <= 5; c++) begin
            // Operands wiggle while busy; the sequencer must ignore them.
            drive(hold, 8'($urandom), 8'($urandom), 1'($urandom));
            case (c)
                1: begin ea = a[3:0]; eb = b[3:0]; end
                2: begin ea = a[3:0]; eb = b[7:4]; end
                3: begin ea = a[7:4]; eb = b[3:0]; end
                4: begin ea = a[7:4]; eb = b[7:4]; end
                default: begin ea = 4'd0; eb = 4'd0; end
            endcase
            check($sformatf("mul_a_c%0d", c), bus20.mul_a, ea);
            check($sformatf("mul_b_c%0d", c), bus20.mul_b, eb);
            check($sformatf("busy_ready_c%0d", c), bus20.in_ready, 1'b0);
            check($sformatf("busy_ovalid_c%0d", c), bus20.out_valid, 1'b0);
            check($sformatf("busy_ovalid16_c%0d", c), bus16.out_valid, 1'b0);
            @(posedge clk); #1;
        end
        check("done_ovalid20", bus20.out_valid, 1'b1);
        check("done_ovalid16", bus16.out_valid, 1'b1);
        check("done_ready", bus20.in_ready, 1'b1);
        check("done_mul_a", bus20.mul_a, 4'd0);
        check_results("done");
        if (!hold) drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        check("idle_ovalid20", bus20.out_valid, 1'b0);
        check("idle_ovalid16", bus16.out_valid, 1'b0);
        check("idle_ready", bus20.in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check("rst_ready", bus20.in_ready, 1'b1);
        check("rst_mul_a", bus20.mul_a, 4'd0);
        check("rst_mul_b", bus20.mul_b, 4'd0);
        check("rst_ovalid", bus20.out_valid, 1'b0);
        check_results("rst");
        rst = 1'b0;
        idle_cycle();

        // Max operands, then ACC_W=16 wrap and sticky overflow, then clear.
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        check("ff_prod_const", bus20.prod_out, 16'hFE01);
        idle_cycle();
        run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        check("wrap16_acc_const", bus16.acc_out, 16'hFC02);
        check("wrap16_ovf_const", bus16.overflow, 1'b1);
        idle_cycle();
        run_op(8'h12, 8'h34, 1'b1, 1'b0);
        check("clr_ovf16_const", bus16.overflow, 1'b0);
        run_op(8'h03, 8'h05, 1'b0, 1'b0);
        run_op(8'hA0, 8'h0B, 1'b0, 1'b0);
        check("seq_acc_const", bus20.acc_out, 20'h00A97);
        idle_cycle();

        // Zero operand leaves the accumulator unchanged.
        run_op(8'h10, 8'h10, 1'b1, 1'b0);
        run_op(8'h00, 8'hC7, 1'b0, 1'b0);
        check("zero_acc_const", bus20.acc_out, 20'h00100);
        idle_cycle();

        // in_valid held high: back-to-back ops, pulses 6 cycles apart.
        for (int k = 0; k < 3; k++)
            run_op(8'($urandom), 8'($urandom), (k == 0) ? 1'b1 : 1'($urandom), 1'b1);
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        idle_cycle();
        idle_cycle();

        // Random traffic with random gaps and occasional clears.
        for (int k = 0; k < 12; k++) begin
            run_op(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
        end

        // Reset in the middle of an op aborts it.
        drive(1'b1, 8'hAB, 8'hCD, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        model_reset();
        check("midrst_ready", bus20.in_ready, 1'b1);
        check("midrst_mul_a", bus20.mul_a, 4'd0);
        check("midrst_mul_b", bus20.mul_b, 4'd0);
        check("midrst_ovalid", bus20.out_valid, 1'b0);
        check_results("midrst");
        rst = 1'b0;
        for (int k = 0; k < 8; k++) idle_cycle();
        check_results("post_rst");

        // A fresh op after the aborted one.
        run_op(8'h07, 8'h09, 1'b0, 1'b0);
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
